// File: rtl/core_mc_seq_if.sv
// Purpose : sequencer <-> datapath/memory bundle for core_mc_seq (fetch, decode flags, lsu, status).
// Latency : n/a (wiring only).
// Backpressure: fetch and lsu requests are held until i_ifu_rsp_valid / i_lsu_done.
// Ports (master = sequencer side):
//   fetch : o_ifu_req, o_ifu_addr, i_ifu_rsp_valid, i_ifu_rsp_ins
//   decode: o_ins, o_pc, i_is_load, i_is_store, i_is_ebreak, i_rdwen, i_a0zero, i_next_pc
//   lsu   : o_lsu_req, i_lsu_done
//   status: o_rd_wen, o_instret, o_cycle, o_halt, o_halt_good, o_err
interface core_mc_seq_if #(
    parameter int XLEN  = 64,
    parameter int CNT_W = 64
);
    logic             o_ifu_req;
    logic [XLEN-1:0]  o_ifu_addr;
    logic             i_ifu_rsp_valid;
    logic [31:0]      i_ifu_rsp_ins;
    logic [31:0]      o_ins;
    logic [XLEN-1:0]  o_pc;
    logic             i_is_load;
    logic             i_is_store;
    logic             i_is_ebreak;
    logic             i_rdwen;
    logic             i_a0zero;
    logic [XLEN-1:0]  i_next_pc;
    logic             o_lsu_req;
    logic             i_lsu_done;
    logic             o_rd_wen;
    logic [CNT_W-1:0] o_instret;
    logic [CNT_W-1:0] o_cycle;
    logic             o_halt;
    logic             o_halt_good;
    logic             o_err;

    modport master (
        output o_ifu_req, o_ifu_addr, o_ins, o_pc, o_lsu_req, o_rd_wen,
               o_instret, o_cycle, o_halt, o_halt_good, o_err,
        input  i_ifu_rsp_valid, i_ifu_rsp_ins, i_is_load, i_is_store, i_is_ebreak,
               i_rdwen, i_a0zero, i_next_pc, i_lsu_done
    );

    modport slave (
        input  o_ifu_req, o_ifu_addr, o_ins, o_pc, o_lsu_req, o_rd_wen,
               o_instret, o_cycle, o_halt, o_halt_good, o_err,
        output i_ifu_rsp_valid, i_ifu_rsp_ins, i_is_load, i_is_store, i_is_ebreak,
               i_rdwen, i_a0zero, i_next_pc, i_lsu_done
    );
endinterface

// File: rtl/core_mc_seq.sv
// Purpose : multi-cycle sequencer (IF/ID/EX/MEM/WB) owning PC, IR, retire counter and halt/error status.
// Latency : 4 cycles per ALU instruction, 5+ per load/store (IF and MEM stretch with memory latency).
// Backpressure: o_ifu_req / o_lsu_req held until response/done; watchdog aborts to ERR after TIMEOUT waits.
// Ports: i_clk, i_rst (sync active-high), bus (core_mc_seq_if.master, see interface header).
// Optional: define CORE_MC_SEQ_PERF_EN to get a live o_cycle counter; otherwise o_cycle is tied to 0.
module core_mc_seq #(
    parameter int              XLEN    = 64,
    parameter logic [XLEN-1:0] RST_PC  = 64'h8000_0000,
    parameter int              TIMEOUT = 1024,
    parameter int              CNT_W   = 64
) (
    input  logic          i_clk,
    input  logic          i_rst,
    core_mc_seq_if.master bus
);
    // Wait counter only needs to reach TIMEOUT-1; the TIMEOUT-th waiting cycle trips it.
    localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [2:0] {
        S_IDLE, S_IF, S_ID, S_EX, S_MEM, S_WB, S_HALT, S_ERR
    } state_t;

    state_t            state;
    logic [XLEN-1:0]   pc;
    logic [31:0]       ir;
    logic [CNT_W-1:0]  instret;
    logic [WAIT_W-1:0] wait_cnt;
    logic              ifu_req;
    logic              lsu_req;
    logic              halt;
    logic              halt_good;
    logic              err;
    logic              timeout_hit;
    logic              next_pc_ok;

    assign timeout_hit = (TIMEOUT != 0) && (wait_cnt == WAIT_LAST);
    assign next_pc_ok  = (bus.i_next_pc[1:0] == 2'b00);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state     <= S_IDLE;
            pc        <= RST_PC;
            ir        <= NOP;
            instret   <= '0;
            wait_cnt  <= '0;
            ifu_req   <= 1'b0;
            lsu_req   <= 1'b0;
            halt      <= 1'b0;
            halt_good <= 1'b0;
            err       <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    state    <= S_IF;
                    ifu_req  <= 1'b1;
                    wait_cnt <= '0;
                end
                S_IF: begin
                    // A response in the same cycle as the timeout still wins.
                    if (bus.i_ifu_rsp_valid) begin
                        ir      <= bus.i_ifu_rsp_ins;
                        ifu_req <= 1'b0;
                        state   <= S_ID;
                    end else if (timeout_hit) begin
                        err     <= 1'b1;
                        ifu_req <= 1'b0;
                        state   <= S_ERR;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end
                S_ID: begin
                    if (bus.i_is_ebreak) begin
                        halt      <= 1'b1;
                        halt_good <= bus.i_a0zero;
                        state     <= S_HALT;
                    end else begin
                        state <= S_EX;
                    end
                end
                S_EX: begin
                    if (bus.i_is_load || bus.i_is_store) begin
                        lsu_req  <= 1'b1;
                        wait_cnt <= '0;
                        state    <= S_MEM;
                    end else begin
                        state <= S_WB;
                    end
                end
                S_MEM: begin
                    if (bus.i_lsu_done) begin
                        lsu_req <= 1'b0;
                        state   <= S_WB;
                    end else if (timeout_hit) begin
                        err     <= 1'b1;
                        lsu_req <= 1'b0;
                        state   <= S_ERR;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end
                S_WB: begin
                    if (next_pc_ok) begin
                        pc       <= bus.i_next_pc;
                        instret  <= instret + CNT_W'(1);
                        ifu_req  <= 1'b1;
                        wait_cnt <= '0;
                        state    <= S_IF;
                    end else begin
                        // Misaligned target: the instruction does not retire.
                        err   <= 1'b1;
                        state <= S_ERR;
                    end
                end
                S_HALT, S_ERR: begin
                    state <= state;
                end
                default: begin
                    state <= S_ERR;
                end
            endcase
        end
    end

    // Write strobe follows the live decode/pcu inputs during WB so the regfile
    // commits on the same edge the PC advances; a misaligned target suppresses it.
    assign bus.o_rd_wen = (state == S_WB) && bus.i_rdwen && next_pc_ok;

`ifdef CORE_MC_SEQ_PERF_EN
    logic [CNT_W-1:0] cycle_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cycle_cnt <= '0;
        end else if (state inside {S_IF, S_ID, S_EX, S_MEM, S_WB}) begin
            cycle_cnt <= cycle_cnt + CNT_W'(1);
        end
    end

    assign bus.o_cycle = cycle_cnt;
`else
    assign bus.o_cycle = '0;
`endif

    assign bus.o_ifu_req   = ifu_req;
    assign bus.o_ifu_addr  = pc;
    assign bus.o_pc        = pc;
    assign bus.o_ins       = ir;
    assign bus.o_lsu_req   = lsu_req;
    assign bus.o_instret   = instret;
    assign bus.o_halt      = halt;
    assign bus.o_halt_good = halt_good;
    assign bus.o_err       = err;
endmodule

// File: tb/tb_core_mc_seq.sv
// Purpose : self-checking bench for core_mc_seq (ALU stream, slow memory, ebreak, timeout, misaligned, reset mid-MEM).
// Latency : n/a.
// Backpressure: fetch/lsu responders answer after programmable delays.
module tb_core_mc_seq;
    localparam int          XLEN   = 64;
    localparam int          CNT_W  = 64;
    localparam logic [63:0] RST_PC = 64'h8000_0000;
    localparam logic [63:0] NOP    = 64'h13;
`ifdef CORE_MC_SEQ_PERF_EN
    localparam logic [63:0] CYC_AT_HALT = 64'd2;
`else
    localparam logic [63:0] CYC_AT_HALT = 64'd0;
`endif

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] ins;
    } rec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    core_mc_seq_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bus ();

    core_mc_seq #(
        .XLEN(XLEN), .RST_PC(RST_PC), .TIMEOUT(16), .CNT_W(CNT_W)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .bus  (bus)
    );

    // Stimulus knobs
    int          fetch_delay = 0;
    int          mem_delay   = 1;
    int          if_cnt      = 0;
    int          mem_cnt     = 0;
    logic        fetch_en    = 1'b1;
    logic        rsp_force   = 1'b0;
    logic        done_force  = 1'b0;
    logic        jump_mis    = 1'b0;
    logic        is_load     = 1'b0;
    logic        is_ebreak   = 1'b0;
    logic        rdwen       = 1'b1;
    logic        a0zero      = 1'b0;
    logic [31:0] ins_drv     = 32'h0010_0093;

    int   n_checks = 0;
    int   n_fail   = 0;
    rec_t sb_q[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Fetch/lsu responders and a pc+4 (or misaligned) pcu model.
    always_comb begin
        bus.i_ifu_rsp_ins   = ins_drv;
        bus.i_ifu_rsp_valid = rsp_force | (bus.o_ifu_req & fetch_en & (if_cnt == fetch_delay));
        bus.i_lsu_done      = done_force | (bus.o_lsu_req & (mem_cnt == mem_delay - 1));
        bus.i_next_pc       = jump_mis ? 64'h8000_0002 : bus.o_pc + 64'd4;
        bus.i_is_load       = is_load;
        bus.i_is_store      = 1'b0;
        bus.i_is_ebreak     = is_ebreak;
        bus.i_rdwen         = rdwen;
        bus.i_a0zero        = a0zero;
    end

    // Push the expected retire record when an instruction is handed to the DUT.
    always @(posedge clk) begin
        if_cnt  <= bus.o_ifu_req ? if_cnt + 1 : 0;
        mem_cnt <= bus.o_lsu_req ? mem_cnt + 1 : 0;
        if (!rst && bus.o_ifu_req && bus.i_ifu_rsp_valid)
            sb_q.push_back({bus.o_pc, bus.i_ifu_rsp_ins});
    end

    // Pop and compare on every register write strobe.
    always @(negedge clk) begin
        rec_t r;
        if (!rst && bus.o_rd_wen) begin
            if (sb_q.size() == 0) begin
                check("sb_underflow", 64'd1, 64'd0);
            end else begin
                r = sb_q.pop_front();
                check("sb_pc", bus.o_pc, r.pc);
                check("sb_ins", 64'(bus.o_ins), 64'(r.ins));
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        sb_q.delete();
    endtask

    initial begin
        int nif;
        int nls;

        // ---------------- ALU stream ----------------
        do_reset();
        check("rst_pc",        bus.o_pc, RST_PC);
        check("rst_ins",       64'(bus.o_ins), NOP);
        check("rst_instret",   bus.o_instret, 64'd0);
        check("rst_cycle",     bus.o_cycle, 64'd0);
        check("rst_halt",      64'(bus.o_halt), 64'd0);
        check("rst_halt_good", 64'(bus.o_halt_good), 64'd0);
        check("rst_err",       64'(bus.o_err), 64'd0);
        check("rst_ifu_req",   64'(bus.o_ifu_req), 64'd0);
        check("rst_lsu_req",   64'(bus.o_lsu_req), 64'd0);
        check("rst_rd_wen",    64'(bus.o_rd_wen), 64'd0);
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            check("alu_wen",   64'(bus.o_rd_wen),  64'(c % 4 == 0));
            check("alu_ifreq", 64'(bus.o_ifu_req), 64'(c % 4 == 1));
            if (c % 4 == 0)
                check("alu_pc", bus.o_pc, RST_PC + 64'(4 * (c / 4 - 1)));
        end
        @(negedge clk);
        check("alu_instret", bus.o_instret, 64'd3);
        check("alu_pc_next", bus.o_pc, RST_PC + 64'd12);

        // ---------------- Slow memory (load) ----------------
        do_reset();
        fetch_delay = 5;
        mem_delay   = 3;
        is_load     = 1'b1;
        ins_drv     = 32'h0000_3083;
        nif = 0;
        nls = 0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            nif += int'(bus.o_ifu_req);
            nls += int'(bus.o_lsu_req);
            check("slow_wen",    64'(bus.o_rd_wen),  64'(c == 12));
            check("slow_lsureq", 64'(bus.o_lsu_req), 64'(c >= 9 && c <= 11));
        end
        check("slow_ifreq_len",  64'(nif), 64'd6);
        check("slow_lsureq_len", 64'(nls), 64'd3);
        @(negedge clk);
        check("slow_instret", bus.o_instret, 64'd1);
        is_load     = 1'b0;
        fetch_delay = 0;
        mem_delay   = 1;

        // ---------------- Ebreak, a0==0 then a0!=0 ----------------
        for (int k = 0; k < 2; k++) begin
            do_reset();
            is_ebreak = 1'b1;
            a0zero    = (k == 0);
            ins_drv   = 32'h0010_0073;
            @(negedge clk);                       // IF
            @(negedge clk);                       // ID
            check("ebk_halt_in_id", 64'(bus.o_halt), 64'd0);
            @(negedge clk);
            check("ebk_halt",      64'(bus.o_halt), 64'd1);
            check("ebk_halt_good", 64'(bus.o_halt_good), 64'(k == 0));
            check("ebk_cycle",     bus.o_cycle, CYC_AT_HALT);
            for (int c = 0; c < 4; c++) begin
                @(negedge clk);
                check("ebk_no_fetch", 64'(bus.o_ifu_req), 64'd0);
            end
            check("ebk_instret",      bus.o_instret, 64'd0);
            check("ebk_cycle_frozen", bus.o_cycle, CYC_AT_HALT);
        end
        is_ebreak = 1'b0;
        ins_drv   = 32'h0010_0093;

        // ---------------- Fetch timeout ----------------
        do_reset();
        fetch_en = 1'b0;
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            check("to_ifreq", 64'(bus.o_ifu_req), 64'd1);
            check("to_err",   64'(bus.o_err), 64'd0);
        end
        @(negedge clk);
        check("to_err_set",   64'(bus.o_err), 64'd1);
        check("to_ifreq_off", 64'(bus.o_ifu_req), 64'd0);
        rsp_force = 1'b1;
        repeat (2) @(negedge clk);
        rsp_force = 1'b0;
        check("to_late_ins",  64'(bus.o_ins), NOP);
        check("to_late_req",  64'(bus.o_ifu_req), 64'd0);
        check("to_late_err",  64'(bus.o_err), 64'd1);
        check("to_late_pc",   bus.o_pc, RST_PC);
        fetch_en = 1'b1;

        // ---------------- Misaligned jump ----------------
        do_reset();
        jump_mis = 1'b1;
        repeat (4) @(negedge clk);                // WB
        check("mis_wen",      64'(bus.o_rd_wen), 64'd0);
        check("mis_err_wb",   64'(bus.o_err), 64'd0);
        @(negedge clk);
        check("mis_err",      64'(bus.o_err), 64'd1);
        check("mis_pc",       bus.o_pc, RST_PC);
        check("mis_instret",  bus.o_instret, 64'd0);
        check("mis_ifreq",    64'(bus.o_ifu_req), 64'd0);
        jump_mis = 1'b0;

        // ---------------- Reset in the middle of MEM ----------------
        do_reset();
        mem_delay = 100;
        repeat (4) @(negedge clk);                // first ALU instr retires
        is_load = 1'b1;
        repeat (4) @(negedge clk);                // second instr in MEM
        check("rm_lsureq",   64'(bus.o_lsu_req), 64'd1);
        check("rm_pc",       bus.o_pc, RST_PC + 64'd4);
        check("rm_instret",  bus.o_instret, 64'd1);
        rst = 1'b1;
        @(negedge clk);
        rst        = 1'b0;
        done_force = 1'b1;
        fetch_en   = 1'b0;
        is_load    = 1'b0;
        sb_q.delete();
        check("rm_rst_pc",      bus.o_pc, RST_PC);
        check("rm_rst_instret", bus.o_instret, 64'd0);
        check("rm_rst_lsureq",  64'(bus.o_lsu_req), 64'd0);
        @(negedge clk);
        check("rm_refetch_req",  64'(bus.o_ifu_req), 64'd1);
        check("rm_refetch_addr", bus.o_ifu_addr, RST_PC);
        check("rm_late_done",    64'(bus.o_lsu_req), 64'd0);
        check("rm_late_instret", bus.o_instret, 64'd0);
        done_force = 1'b0;
        fetch_en   = 1'b1;
        repeat (3) @(negedge clk);                // ID, EX, WB
        check("rm_wb_wen", 64'(bus.o_rd_wen), 64'd1);
        @(negedge clk);
        check("rm_instret_after", bus.o_instret, 64'd1);
        check("rm_pc_after",      bus.o_pc, RST_PC + 64'd4);

        check("sb_drain", 64'(sb_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
